// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device transmitter.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XMIT = 2'd1,
        ST_GAP  = 2'd2
    } ps2_state_e;

    localparam int FRAME_BITS = 11;

    // PS/2 uses odd parity: the nine data+parity bits carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Byte FIFO feeding the PS/2 transmitter; level carries one extra bit to tell full from empty.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 wr,
    input  logic [7:0]           din,
    input  logic                 pop,
    input  logic                 flush,
    output logic [7:0]           dout,
    output logic [FIFO_BITS:0]   level
);

    localparam int                 DEPTH   = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS-1:0] PTR_ONE = FIFO_BITS'(1'b1);
    localparam logic [FIFO_BITS:0]   LVL_ONE = (FIFO_BITS+1)'(1'b1);

    logic [7:0]           mem_r [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_r;
    logic [FIFO_BITS-1:0] rd_ptr_r;
    logic [FIFO_BITS:0]   level_r;
    logic                 push_s;

    assign push_s = wr & ~flush;

    // Storage array, written at the tail.
    always_ff @(posedge clk_sys) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at 2**FIFO_BITS; flush empties in one cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host transmitter: clock divider, frame FSM and host-inhibit handling around a byte FIFO.
module ps2_dev_tx
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 wr,
    input  logic [7:0]           din,
    input  logic                 flush,
    input  logic                 ps2_clk_in,
    output logic                 ps2_clk_out,
    output logic                 ps2_data_out,
    output logic                 busy,
    output logic [FIFO_BITS:0]   level,
    output logic                 full,
    output logic                 overflow
);

    localparam int                 DEPTH    = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] DEPTH_L  = (FIFO_BITS+1)'(DEPTH);
    localparam logic [FIFO_BITS:0] LVL_ONE  = (FIFO_BITS+1)'(1'b1);
    localparam logic [FIFO_BITS:0] LVL_ZERO = (FIFO_BITS+1)'(1'b0);
    localparam logic [11:0]        DIV_MAX  = 12'(PS2DIV);
    localparam logic [3:0]         LAST_BIT = 4'(FRAME_BITS - 1);

    ps2_state_e         state_r, state_nxt;
    logic [11:0]        div_cnt_r;
    logic               clk_ps2_r, clk_ps2_nxt_s;
    logic               div_wrap_s, tick_s, fall_s;
    logic               clk_meta_r, clk_sync_r, inhibit_s;
    logic [3:0]         bit_cnt_r, bit_nxt_s;
    logic [9:0]         shift_r, shift_nxt_s;
    logic               data_r, data_nxt_s;
    logic               clk_out_r, busy_r, full_r, overflow_r;
    logic               pop_s, wr_acc_s;
    logic [7:0]         head_s;
    logic [FIFO_BITS:0] level_s, level_nxt_s;

    ps2_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr      (wr_acc_s),
        .din     (din),
        .pop     (pop_s),
        .flush   (flush),
        .dout    (head_s),
        .level   (level_s)
    );

    assign div_wrap_s    = (div_cnt_r == DIV_MAX);
    assign tick_s        = div_wrap_s & ~clk_ps2_r;
    assign fall_s        = div_wrap_s & clk_ps2_r;
    assign clk_ps2_nxt_s = clk_ps2_r ^ div_wrap_s;
    assign inhibit_s     = ~clk_sync_r;

    // Half-period divider producing the internal PS/2 clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_r <= 12'd0;
            clk_ps2_r <= 1'b0;
        end else if (div_wrap_s) begin
            div_cnt_r <= 12'd0;
            clk_ps2_r <= ~clk_ps2_r;
        end else begin
            div_cnt_r <= div_cnt_r + 12'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous host clock line.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
        end
    end

    // FSM state and frame datapath registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 10'd0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Next-state logic; the host inhibits by holding the clock low at our falling edge.
    always_comb begin
        state_nxt = state_r;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s && (level_s != LVL_ZERO) && !inhibit_s) begin
                        state_nxt = ST_XMIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_XMIT: begin
                    if (fall_s && inhibit_s) begin
                        state_nxt = ST_IDLE;
                    end else if (tick_s && (bit_cnt_r == LAST_BIT)) begin
                        state_nxt = ST_GAP;
                    end else begin
                        state_nxt = ST_XMIT;
                    end
                end
                ST_GAP: begin
                    if ((fall_s && inhibit_s) || tick_s) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // The head byte is popped only on leaving GAP, so an aborted frame is resent whole.
    assign pop_s    = (state_r == ST_GAP) & tick_s & ~flush;
    assign wr_acc_s = wr & ~flush & (~full_r | pop_s);

    // Output/datapath logic: shift register holds data, parity, stop after the start bit.
    always_comb begin
        bit_nxt_s   = bit_cnt_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        if (flush || (state_nxt == ST_IDLE)) begin
            bit_nxt_s  = 4'd0;
            data_nxt_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            bit_nxt_s   = 4'd0;
            shift_nxt_s = {1'b1, odd_parity(head_s), head_s};
            data_nxt_s  = 1'b0;
        end else if (tick_s && (state_r == ST_XMIT)) begin
            bit_nxt_s   = bit_cnt_r + 4'd1;
            data_nxt_s  = shift_r[0];
            shift_nxt_s = {1'b1, shift_r[9:1]};
        end else begin
            bit_nxt_s = bit_cnt_r;
        end
    end

    assign level_nxt_s = level_s + (wr_acc_s ? LVL_ONE : LVL_ZERO) - (pop_s ? LVL_ONE : LVL_ZERO);

    // Registered line drives and status, computed from next-state values to stay cycle-aligned.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_out_r  <= 1'b1;
            data_r     <= 1'b1;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            clk_out_r <= clk_ps2_nxt_s | (state_nxt == ST_IDLE);
            data_r    <= data_nxt_s;
            busy_r    <= (state_nxt != ST_IDLE);
            if (flush) begin
                full_r     <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                full_r     <= (level_nxt_s == DEPTH_L);
                overflow_r <= overflow_r | (wr & full_r & ~pop_s);
            end
        end
    end

    assign ps2_clk_out  = clk_out_r;
    assign ps2_data_out = data_r;
    assign busy         = busy_r;
    assign full         = full_r;
    assign overflow     = overflow_r;
    assign level        = level_s;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx with PS2DIV=4 (10-cycle bit period) and an 8-byte FIFO.
module tb_ps2_dev_tx;

    logic       clk_sys;
    logic       reset_n;
    logic       wr;
    logic [7:0] din;
    logic       flush;
    logic       ps2_clk_in;
    logic       ps2_clk_out;
    logic       ps2_data_out;
    logic       busy;
    logic [3:0] level;
    logic       full;
    logic       overflow;

    int vectors;
    int miscompares;

    ps2_dev_tx #(.FIFO_BITS(3), .PS2DIV(4)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .wr           (wr),
        .din          (din),
        .flush        (flush),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .busy         (busy),
        .level        (level),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input int limit, output int n);
        n = 0;
        while (!busy && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    // Called on the first negedge with busy high; samples data at each falling ps2_clk_out.
    task automatic collect_frame(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        int          idx;
        int          hi;
        int          cyc;
        logic        prev;
        got  = 11'd0;
        idx  = 0;
        hi   = 1;
        cyc  = 0;
        prev = ps2_clk_out;
        while (busy && cyc < 300) begin
            @(negedge clk_sys);
            cyc++;
            if (prev && !ps2_clk_out && idx < 11) begin
                got[idx] = ps2_data_out;
                idx++;
            end
            prev = ps2_clk_out;
            if (busy) hi++;
        end
        check({tag, "_bits"}, 32'(got), 32'(exp));
        check({tag, "_busy_len"}, 32'(hi), 32'd120);
    endtask

    initial begin
        int n;
        int seen;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        wr          = 1'b0;
        din         = 8'h00;
        flush       = 1'b0;
        ps2_clk_in  = 1'b1;

        repeat (3) @(negedge clk_sys);
        check("rst_clk_out", 32'(ps2_clk_out), 32'd1);
        check("rst_data_out", 32'(ps2_data_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Release reset with a write in the same cycle: first tick lands 5 cycles later.
        reset_n = 1'b1;
        wr      = 1'b1;
        din     = 8'h1C;
        @(negedge clk_sys);
        wr = 1'b0;
        check("level_one", 32'(level), 32'd1);
        wait_busy(50, n);
        check("first_tick_latency", 32'(n + 1), 32'd5);
        check("start_bit_low", 32'(ps2_data_out), 32'd0);
        collect_frame("frame_1c", 11'b10000111000);
        check("level_after_1c", 32'(level), 32'd0);
        check("idle_clk_released", 32'(ps2_clk_out), 32'd1);

        // Idle-inhibited burst of 9 writes into an 8-deep FIFO.
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 9; i++) begin
            wr  = 1'b1;
            din = 8'(8'h10 + i);
            @(negedge clk_sys);
        end
        wr = 1'b0;
        repeat (12) @(negedge clk_sys);
        check("burst_level", 32'(level), 32'd8);
        check("burst_full", 32'(full), 32'd1);
        check("burst_overflow", 32'(overflow), 32'd1);
        check("burst_no_frame", 32'(busy), 32'd0);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_full", 32'(full), 32'd0);

        // Host inhibit during bit 4 aborts; release resends the whole byte.
        ps2_clk_in = 1'b1;
        repeat (3) @(negedge clk_sys);
        wr  = 1'b1;
        din = 8'h1C;
        @(negedge clk_sys);
        wr = 1'b0;
        wait_busy(40, n);
        check("abort_frame_start", 32'(busy), 32'd1);
        repeat (42) @(negedge clk_sys);
        ps2_clk_in = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_data_released", 32'(ps2_data_out), 32'd1);
        check("abort_level_kept", 32'(level), 32'd1);
        repeat (30) @(negedge clk_sys);
        check("abort_held_idle", 32'(busy), 32'd0);
        ps2_clk_in = 1'b1;
        wait_busy(40, n);
        check("resend_start", 32'(busy), 32'd1);
        collect_frame("resend_1c", 11'b10000111000);
        check("resend_level", 32'(level), 32'd0);

        // Fill while inhibited, then write exactly on the GAP-exit pop cycle.
        ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            wr  = 1'b1;
            din = (i == 0) ? 8'hA5 : 8'(8'h30 + i);
            @(negedge clk_sys);
        end
        wr = 1'b0;
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd0);
        ps2_clk_in = 1'b1;
        wait_busy(40, n);
        check("gapwr_start", 32'(busy), 32'd1);
        repeat (119) @(negedge clk_sys);
        wr  = 1'b1;
        din = 8'h77;
        @(negedge clk_sys);
        wr = 1'b0;
        check("gapwr_level", 32'(level), 32'd8);
        check("gapwr_full", 32'(full), 32'd1);
        check("gapwr_overflow", 32'(overflow), 32'd0);
        check("gapwr_idle", 32'(busy), 32'd0);
        repeat (20) @(negedge clk_sys);
        check("refill_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        check("midflush_busy", 32'(busy), 32'd0);
        check("midflush_data", 32'(ps2_data_out), 32'd1);
        check("midflush_level", 32'(level), 32'd0);

        // Reset pulse during bit 6 discards everything.
        repeat (5) @(negedge clk_sys);
        wr  = 1'b1;
        din = 8'h1C;
        @(negedge clk_sys);
        wr = 1'b0;
        wait_busy(40, n);
        repeat (62) @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("midrst_clk_out", 32'(ps2_clk_out), 32'd1);
        check("midrst_data_out", 32'(ps2_data_out), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (busy) seen++;
        end
        check("postrst_no_frame", 32'(seen), 32'd0);
        wr  = 1'b1;
        din = 8'h00;
        @(negedge clk_sys);
        wr = 1'b0;
        wait_busy(40, n);
        check("frame_00_start", 32'(busy), 32'd1);
        collect_frame("frame_00", 11'b11000000000);
        check("level_after_00", 32'(level), 32'd0);

        // A second distinct data pattern.
        wr  = 1'b1;
        din = 8'hA5;
        @(negedge clk_sys);
        wr = 1'b0;
        wait_busy(40, n);
        check("frame_a5_start", 32'(busy), 32'd1);
        collect_frame("frame_a5", 11'b11101001010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 SHALL have parameter FIFO_BITS, default 3, giving FIFO depth 2**FIFO_BITS bytes (range 1..6).
REQ-002 SHALL have parameter PS2DIV, default 100: the PS/2 clock half-period is PS2DIV+1 clk_sys cycles (range 4..4095).
REQ-003 SHALL have port clk_sys  in  1  the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  in  1  one-cycle strobe that enqueues din.
REQ-006 SHALL have port din  in  8  byte to enqueue.
REQ-007 SHALL have port flush  in  1  one-cycle strobe that empties the FIFO and aborts any frame.
REQ-008 SHALL have port ps2_clk_in  in  1  sensed host clock line (open-collector bus, asynchronous).
REQ-009 SHALL have port ps2_clk_out  out  1  device clock drive; 1 means released.
REQ-010 SHALL have port ps2_data_out  out  1  device data drive; 1 means released.
REQ-011 SHALL have port busy  out  1  high while a frame is in progress.
REQ-012 SHALL have port level  out  FIFO_BITS+1  number of queued bytes.
REQ-013 SHALL have port full  out  1  high when level equals 2**FIFO_BITS.
REQ-014 SHALL have port overflow  out  1  sticky flag, set when a byte is dropped.

Function
REQ-015 SHALL toggle internal clk_ps2 every PS2DIV+1 clk_sys cycles; tick = rising edge of clk_ps2; bit period = 2*(PS2DIV+1) cycles.
REQ-016 SHALL drive ps2_clk_out = clk_ps2 OR (state==IDLE).
REQ-017 SHALL implement states IDLE -> XMIT(bit 0..10) -> GAP -> IDLE, with every transition taken on a tick.
REQ-018 In IDLE, on a tick with level>0 and no inhibit, SHALL load the head byte, drive start bit 0, and enter XMIT bit 0.
REQ-019 XMIT bits 1..8 SHALL shift out data LSB first; bit 9 SHALL be odd parity (1 XOR all data bits); bit 10 SHALL be stop bit 1; the next state is GAP.
REQ-020 SHALL pop the head byte only when leaving GAP, so that an aborted byte stays queued.
REQ-021 SHALL synchronise ps2_clk_in through 2 flops; inhibit = synced value 0 sampled at a falling edge of clk_ps2 while busy, or on any cycle while IDLE.
REQ-022 On inhibit while busy, SHALL go to IDLE at once, drive ps2_data_out=1, keep the FIFO unchanged, and retransmit the whole byte after release.
REQ-023 A wr with full=1 SHALL drop the byte and set overflow; level SHALL be unchanged.
REQ-024 A wr on the same cycle as a pop SHALL leave level unchanged and be accepted even when full.
REQ-025 flush SHALL, within 1 cycle, set level=0, overflow=0, state=IDLE and ps2_data_out=1; flush SHALL win over a simultaneous wr.
REQ-026 SHALL hold busy = (state != IDLE) and register it, with no combinational path from any input to any output.
REQ-027 Pointers SHALL wrap modulo 2**FIFO_BITS; level SHALL be computed with one extra bit.

Reset
REQ-028 While reset_n=0, SHALL hold ps2_clk_out=1, ps2_data_out=1, busy=0, level=0, full=0, overflow=0, state=IDLE, divider=0, clk_ps2=0, and both pointers at 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame and the FIFO contents; after release the first tick SHALL occur PS2DIV+1 cycles later.

Structure
REQ-030 Package ps2_pkg SHALL hold the state enum, FRAME_BITS=11 and the parity helper function.
REQ-031 The FIFO SHALL be sub-module ps2_fifo (parameter FIFO_BITS; ports wr, din, pop, flush, dout, level); the divider and FSM stay in ps2_dev_tx.

Verification (PS2DIV=4, FIFO_BITS=3; bit period 10 cycles)
REQ-032 wr din=0x1C -> data sequence 0,0,0,1,1,1,0,0,0,0,1 on successive ticks; level returns to 0 after GAP; busy covers 12 ticks.
REQ-033 9 wr strobes back-to-back while idle-inhibited -> level=8, full=1, overflow=1; later flush -> level=0, overflow=0.
REQ-034 Send 0x1C, hold ps2_clk_in=0 during bit 4 -> IDLE and ps2_data_out=1; release -> complete 0x1C frame resent and level decrements once.
REQ-035 With full=1, wr on the GAP-exit cycle -> byte accepted, level stays 8, overflow stays 0.
REQ-036 reset_n pulsed low during bit 6 -> all outputs at reset values; no further frames until a new wr.
